uart_tx_sched: RTL and testbench
================================

# uart_tx_sched

Two-port transmit scheduler for the UART TX path. It arbitrates byte writes from the core's OUT instruction port and the loader/handshake port (e.g. the 0xAA sync byte) into one circular FIFO. It then drains that FIFO into `uart_tx` using a `tx_start`/`tx_busy` handshake. It sits between the execute stage and `uart_tx` and replaces ad-hoc TX ring-buffer logic inside the execute stage.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries; power of two, at least 2.
- `AW`, `$clog2(DEPTH)`: pointer width, derived.

Ports:
- `clk` input 1: sole clock; everything is on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req0_valid` input 1: core OUT byte request.
- `req0_data` input 8: core byte.
- `req0_ready` output 1: core byte accepted this cycle.
- `req1_valid` input 1: loader/handshake byte request.
- `req1_data` input 8: loader byte.
- `req1_ready` output 1: loader byte accepted this cycle.
- `tx_data` output 8: byte to `uart_tx`; registered.
- `tx_start` output 1: one-cycle start pulse to `uart_tx`; registered.
- `tx_busy` input 1: `uart_tx` busy.
- `fifo_level` output AW+1: occupancy, 0..DEPTH.
- `fifo_empty` output 1: `fifo_level == 0`.
- `fifo_full` output 1: `fifo_level == DEPTH`.
- `idle` output 1: FIFO is empty, the FSM is in IDLE, and `tx_busy` is low.
- `sent_count` output 32: bytes launched; only present with `UART_TX_SCHED_COUNT_EN`.

## Operation
- **Storage.**
  - `DEPTH` × 8 register array.
  - Read and write pointers are AW+1 bits, so the MSB is a wrap bit.
  - Level = wr − rd, modulo 2^(AW+1). Pointers wrap naturally and never saturate.
- **Accept.**
  - At most one byte is pushed per cycle.
  - `req*_ready` is combinational from valid, the registered `fifo_full`, and the round-robin flag `rr`.
  - A push completes when valid && ready.
- **Arbitration.**
  - Full: both readies are 0. A same-cycle pop does not free the slot for that cycle.
  - Only one port valid: that port is granted.
  - Both ports valid: the port ≠ `rr` is granted (`rr` = last granted port).
  - `rr` updates only on a grant. Reset value is `rr`=1, so port 0 wins the first tie.
- **Drain FSM** (states IDLE, HOLD, WAIT):
  - IDLE: if `fifo_level != 0` and `!tx_busy`, then register `tx_data` <= mem[rd], `tx_start` <= 1, rd++, and go to HOLD.
  - HOLD: `tx_start` <= 0, go to WAIT. This is an unconditional one-cycle hold that covers `uart_tx`'s one-cycle busy-assertion latency.
  - WAIT: on `!tx_busy` go to IDLE.
- **Push and pop together.** The level is unchanged, and both pointers advance.
- **Byte order.** Bytes are transmitted in strict push order across both ports. No byte is dropped or duplicated.
- **Reset.** Reset is honoured mid-frame. The FIFO content and pointers are discarded, and the FSM returns to IDLE. Any frame already in flight inside `uart_tx` is not this block's concern.

## Timing
Reset values:
- `tx_start`=0, `tx_data`=0, state=IDLE.
- wr=rd=0, so `fifo_level`=0, `fifo_empty`=1, `fifo_full`=0.
- `rr`=1, `idle`=1, `sent_count`=0.

Latency:
- A byte pushed on edge N into an empty FIFO with the FSM idle and `tx_busy` low is launched on edge N+1. `tx_start` is high for exactly the cycle after edge N+1.
- `tx_start` is never high on two consecutive cycles.
- The minimum spacing between starts is 3 cycles, plus the `tx_busy` duration.
- `fifo_level`/`fifo_empty`/`fifo_full` update on the edge after the push or pop.
- `req*_ready` depends on same-cycle `req*_valid`. This is a combinational path; there is no loop, because ready never feeds valid.

## Configuration
- `UART_TX_SCHED_COUNT_EN` defined:
  - `sent_count` port exists.
  - It increments by 1 on each IDLE→HOLD transition, wraps at 2^32, and clears on `rst`.
- Undefined:
  - The port and counter are absent.
  - All other behaviour is identical.

## Test plan
- **Reset then single push.** Drive `rst` 2 cycles, then port 0 pushes 0x41 at edge 5. Required: `tx_start` is high only in the cycle after edge 6 with `tx_data`=0x41, and `idle` returns to 1 after `tx_busy` falls.
- **Tie, alternating grants.** Both ports hold valid with 0x10/0x20 for 4 cycles. Required: grants go 0,1,0,1, and bytes transmit in the order 0x10,0x20,0x10,0x20.
- **Full.** Hold `tx_busy`=1 and push 16 bytes 0x00..0x0F. Required: `fifo_full`=1, and both readies are 0 on the 17th attempt. After release, 0x00..0x0F transmit in order and `fifo_level` counts down to 0.
- **Wrap and simultaneous push/pop.** Stream 40 bytes on port 1, one push per cycle whenever ready. The bench model's `uart_tx` busy is 3 cycles per byte. Required: all 40 bytes arrive in order across pointer wrap, and `fifo_level` never exceeds 16.
- **Mid-operation reset.** Assert `rst` with level 5 while in WAIT. Required: the next cycle shows level 0, state IDLE, `tx_start`=0, and no further starts until a new push.
- **Counter.** With `UART_TX_SCHED_COUNT_EN`, after 7 launches `sent_count`=7. After `rst`, it is 0.

Source files
------------

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: two-port round-robin byte scheduler feeding uart_tx through a circular FIFO.
// Define UART_TX_SCHED_COUNT_EN to add the sent_count launch counter port.
module uart_tx_sched #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic [7:0]  req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [7:0]  req1_data,
    output logic        req1_ready,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_busy,
    output logic [AW:0] fifo_level,
    output logic        fifo_empty,
    output logic        fifo_full,
    output logic        idle
`ifdef UART_TX_SCHED_COUNT_EN
    ,
    output logic [31:0] sent_count
`endif
);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("uart_tx_sched: DEPTH must be a power of two >= 2");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_HOLD,
        S_WAIT
    } state_t;

    localparam logic [AW:0] ONE  = (AW+1)'(1);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_mem [DEPTH];
    logic [AW:0] r_wr;
    logic [AW:0] r_rd;
    logic        r_rr;
    logic [7:0]  r_tx_data;
    logic        r_tx_start;

    logic [AW:0] w_level;
    logic        w_full;
    logic        w_empty;
    logic        w_gnt0;
    logic        w_gnt1;
    logic        w_push;
    logic        w_pop;
    logic [7:0]  w_push_data;

    // Pointers carry a wrap bit, so the difference is the true occupancy.
    assign w_level = r_wr - r_rd;
    assign w_full  = (w_level == FULL);
    assign w_empty = (w_level == '0);

    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!w_full) begin
            if (req0_valid && req1_valid) begin
                w_gnt0 = r_rr;
                w_gnt1 = !r_rr;
            end else begin
                w_gnt0 = req0_valid;
                w_gnt1 = req1_valid;
            end
        end
    end

    assign w_push      = w_gnt0 || w_gnt1;
    assign w_push_data = w_gnt0 ? req0_data : req1_data;

    // HOLD covers the cycle before uart_tx raises busy.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (!w_empty && !tx_busy) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (!tx_busy) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_wr       <= '0;
            r_rd       <= '0;
            r_rr       <= 1'b1;
            r_tx_data  <= '0;
            r_tx_start <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_tx_start <= w_pop;
            if (w_pop) begin
                r_tx_data <= r_mem[r_rd[AW-1:0]];
                r_rd      <= r_rd + ONE;
            end
            if (w_push) begin
                r_wr <= r_wr + ONE;
                r_rr <= w_gnt1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem[r_wr[AW-1:0]] <= w_push_data;
        end
    end

`ifdef UART_TX_SCHED_COUNT_EN
    logic [31:0] r_sent;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sent <= '0;
        end else if (w_pop) begin
            r_sent <= r_sent + 32'd1;
        end
    end

    assign sent_count = r_sent;
`endif

    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;
    assign tx_data    = r_tx_data;
    assign tx_start   = r_tx_start;
    assign fifo_level = w_level;
    assign fifo_empty = w_empty;
    assign fifo_full  = w_full;
    assign idle       = w_empty && (r_state == S_IDLE) && !tx_busy;

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: directed bench with a push-order queue model and a 3-cycle uart_tx busy model.
// Build with UART_TX_SCHED_COUNT_EN to also exercise sent_count.
module tb_uart_tx_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0_valid = 1'b0;
    logic [7:0] req0_data = '0;
    logic       req0_ready;
    logic       req1_valid = 1'b0;
    logic [7:0] req1_data = '0;
    logic       req1_ready;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;
    logic [4:0] fifo_level;
    logic       fifo_empty;
    logic       fifo_full;
    logic       idle;
`ifdef UART_TX_SCHED_COUNT_EN
    logic [31:0] sent_count;
`endif

    uart_tx_sched #(.DEPTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .tx_busy    (tx_busy),
        .fifo_level (fifo_level),
        .fifo_empty (fifo_empty),
        .fifo_full  (fifo_full),
        .idle       (idle)
`ifdef UART_TX_SCHED_COUNT_EN
        ,
        .sent_count (sent_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // uart_tx stand-in: busy for 3 cycles after each observed start pulse
    logic hold_busy = 1'b0;
    int   busy_left = 0;
    assign tx_busy = hold_busy || (busy_left != 0);

    always @(posedge clk) begin
        cyc++;
        #2;
        if (tx_start) busy_left = 3;
        else if (busy_left > 0) busy_left--;
    end

    // Model: FIFO as a queue of bytes in push order, drain gate as launch timing rules
    logic [7:0] mq[$];
    logic       m_rr = 1'b1;
    logic       m_free = 1'b1;
    logic       m_skip = 1'b0;
    logic       m_start = 1'b0;
    logic [7:0] m_data = '0;
    int         m_sent = 0;
    int         max_level = 0;

    logic [7:0] tx_log[$];
    int         cyc_log[$];
    int         gnt_log[$];

    always @(negedge clk) begin
        logic e_r0;
        logic e_r1;
        logic full;
        full = (mq.size() == 16);
        e_r0 = 1'b0;
        e_r1 = 1'b0;
        if (!full) begin
            if (req0_valid && req1_valid) begin
                e_r0 = m_rr;
                e_r1 = !m_rr;
            end else begin
                e_r0 = req0_valid;
                e_r1 = req1_valid;
            end
        end
        if (cyc > 0) begin
            chk("tx_start", 32'(tx_start), 32'(m_start));
            chk("tx_data", 32'(tx_data), 32'(m_data));
            chk("fifo_level", 32'(fifo_level), mq.size());
            chk("fifo_empty", 32'(fifo_empty), 32'(mq.size() == 0));
            chk("fifo_full", 32'(fifo_full), 32'(full));
            chk("req0_ready", 32'(req0_ready), 32'(e_r0));
            chk("req1_ready", 32'(req1_ready), 32'(e_r1));
            chk("idle", 32'(idle), 32'(mq.size() == 0 && m_free && !tx_busy));
`ifdef UART_TX_SCHED_COUNT_EN
            chk("sent_count", sent_count, m_sent);
`endif
            if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
            if (tx_start) begin
                tx_log.push_back(tx_data);
                cyc_log.push_back(cyc);
            end
            if (!rst && req0_ready) gnt_log.push_back(0);
            if (!rst && req1_ready) gnt_log.push_back(1);
        end
        if (rst) begin
            mq.delete();
            m_rr = 1'b1;
            m_free = 1'b1;
            m_skip = 1'b0;
            m_start = 1'b0;
            m_data = '0;
            m_sent = 0;
        end else begin
            m_start = 1'b0;
            if (m_free) begin
                if (mq.size() > 0 && !tx_busy) begin
                    m_start = 1'b1;
                    m_data = mq.pop_front();
                    m_sent++;
                    m_free = 1'b0;
                    m_skip = 1'b1;
                end
            end else if (m_skip) begin
                m_skip = 1'b0;
            end else if (!tx_busy) begin
                m_free = 1'b1;
            end
            if (e_r0) begin
                mq.push_back(req0_data);
                m_rr = 1'b0;
            end else if (e_r1) begin
                mq.push_back(req1_data);
                m_rr = 1'b1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while (!idle && n < 1000) begin
            step();
            n++;
        end
        if (n >= 1000) begin
            checks++;
            failures++;
            $display("FAIL %s idle timeout", nm);
        end
    endtask

    initial begin
        int base;
        int gbase;
        int k;
        int n;
        logic acc;

        // Reset then single push: rst over edges 1-2, push sampled at edge 5
        step();
        step();
        rst = 1'b0;
        chk("rst_empty", 32'(fifo_empty), 1);
        chk("rst_level", 32'(fifo_level), 0);
        chk("rst_start", 32'(tx_start), 0);
        chk("rst_idle", 32'(idle), 1);
        base = tx_log.size();
        step();
        step();
        req0_valid = 1'b1;
        req0_data = 8'h41;
        step();
        req0_valid = 1'b0;
        wait_idle("single");
        chk("single_count", tx_log.size() - base, 1);
        if (tx_log.size() > base) begin
            chk("single_cycle", cyc_log[base], 6);
            chk("single_data", 32'(tx_log[base]), 32'h41);
        end

        // Tie: alternating grants from reset value of rr
        do_reset();
        base = tx_log.size();
        gbase = gnt_log.size();
        req0_valid = 1'b1;
        req0_data = 8'h10;
        req1_valid = 1'b1;
        req1_data = 8'h20;
        repeat (4) step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_idle("tie");
        chk("tie_grants", gnt_log.size() - gbase, 4);
        chk("tie_bytes", tx_log.size() - base, 4);
        if (gnt_log.size() >= gbase + 4 && tx_log.size() >= base + 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("tie_gnt", gnt_log[gbase+i], i % 2);
                chk("tie_data", 32'(tx_log[base+i]), (i % 2 == 0) ? 32'h10 : 32'h20);
            end
        end

        // Full: stall the drain and fill all 16 slots
        hold_busy = 1'b1;
        do_reset();
        base = tx_log.size();
        for (int i = 0; i < 16; i++) begin
            req0_valid = 1'b1;
            req0_data = 8'(i);
            step();
        end
        req1_valid = 1'b1;
        req1_data = 8'hEE;
        #1;
        chk("full_flag", 32'(fifo_full), 1);
        chk("full_level", 32'(fifo_level), 16);
        chk("full_r0", 32'(req0_ready), 0);
        chk("full_r1", 32'(req1_ready), 0);
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        hold_busy = 1'b0;
        wait_idle("full");
        chk("full_bytes", tx_log.size() - base, 16);
        if (tx_log.size() >= base + 16) begin
            for (int i = 0; i < 16; i++) chk("full_data", 32'(tx_log[base+i]), i);
        end

        // Wrap: stream 40 bytes on port 1 while draining
        do_reset();
        base = tx_log.size();
        max_level = 0;
        k = 0;
        n = 0;
        while (k < 40 && n < 2000) begin
            req1_valid = 1'b1;
            req1_data = 8'(32'h80 + k);
            @(negedge clk);
            acc = req1_ready;
            step();
            n++;
            if (acc) k++;
        end
        req1_valid = 1'b0;
        chk("wrap_pushed", k, 40);
        wait_idle("wrap");
        chk("wrap_bytes", tx_log.size() - base, 40);
        if (tx_log.size() >= base + 40) begin
            for (int i = 0; i < 40; i++) chk("wrap_data", 32'(tx_log[base+i]), 32'h80 + i);
        end
        chk("wrap_maxlvl", max_level, 16);

        // Mid-operation reset with level 5 while waiting on uart_tx
        do_reset();
        base = tx_log.size();
        req0_valid = 1'b1;
        req0_data = 8'h5A;
        step();
        req0_valid = 1'b0;
        n = 0;
        while (tx_log.size() == base && n < 50) begin
            step();
            n++;
        end
        chk("mid_launch", tx_log.size() - base, 1);
        hold_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            req0_valid = 1'b1;
            req0_data = 8'(32'h60 + i);
            step();
        end
        req0_valid = 1'b0;
        chk("mid_level5", 32'(fifo_level), 5);
        chk("mid_notidle", 32'(idle), 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        hold_busy = 1'b0;
        chk("mid_level0", 32'(fifo_level), 0);
        chk("mid_empty", 32'(fifo_empty), 1);
        chk("mid_start", 32'(tx_start), 0);
        repeat (8) step();
        chk("mid_nostart", tx_log.size() - base, 1);
        chk("mid_idle", 32'(idle), 1);

`ifdef UART_TX_SCHED_COUNT_EN
        // Counter: seven launches, then cleared by reset
        do_reset();
        for (int i = 0; i < 7; i++) begin
            req0_valid = 1'b1;
            req0_data = 8'(32'hC0 + i);
            step();
        end
        req0_valid = 1'b0;
        wait_idle("count");
        chk("count_7", sent_count, 7);
        do_reset();
        chk("count_rst", sent_count, 0);
`endif

        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
